multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback over multiple cycles, sharing one ALU and one unified instruction/data memory. It decodes the same opcode set as the single-cycle main decoder. Memory accesses stall on a ready handshake. It sits beside the ALU decoder, which consumes `aluop` and `funct`/`op`.

---
 rtl/mc_ctrl_pkg.sv | 66 ++++++
 rtl/mc_ctrl_outdec.sv | 81 ++++++++
 rtl/multicycle_ctrl.sv | 155 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// MULTICYCLE_CTRL_ILLEGAL_TRAP_EN adds the TRAP state to statetype_t.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_RTEXE,
      S_ALUWB,
      S_BRANCH,
      S_IEXE,
      S_IWB,
      S_JUMP
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      , S_TRAP
`endif
   } statetype_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_SRLV  = 6'b000110;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LI    = 6'b010001;
   localparam logic [5:0] OP_BGTZ  = 6'b011101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_IMM   = 2'b11;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_SHIMM = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       bgtz;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
      logic       instr_done;
   } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state/opcode to control-vector decode for multicycle_ctrl.
module mc_ctrl_outdec
   import mc_ctrl_pkg::*;
(
   input  statetype_t  state_i,
   input  logic [5:0]  op_i,
   input  logic        mem_ready_i,
   output ctrl_t       ctrl_o
);

   // Moore decode; only the fetch enables and the store completion follow mem_ready
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.alusrcb = SRCB_FOUR;
            ctrl_o.aluop   = ALUOP_ADD;
            ctrl_o.pcsrc   = PCSRC_ALU;
            ctrl_o.irwrite = mem_ready_i;
            ctrl_o.pcwrite = mem_ready_i;
         end
         S_DECODE: begin
            ctrl_o.alusrcb = SRCB_SHIMM;
            ctrl_o.aluop   = ALUOP_ADD;
         end
         S_MEMADR: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.aluop   = ALUOP_ADD;
         end
         S_MEMRD: begin
            ctrl_o.iord = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.memtoreg   = 1'b1;
            ctrl_o.regwrite   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.iord       = 1'b1;
            ctrl_o.memwrite   = 1'b1;
            ctrl_o.instr_done = mem_ready_i;
         end
         S_RTEXE: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_B;
            ctrl_o.aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl_o.regdst     = 1'b1;
            ctrl_o.regwrite   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alusrca    = 1'b1;
            ctrl_o.alusrcb    = SRCB_B;
            ctrl_o.pcsrc      = PCSRC_ALUOUT;
            ctrl_o.branch     = 1'b1;
            ctrl_o.instr_done = 1'b1;
            ctrl_o.bgtz       = (op_i == OP_BGTZ);
            ctrl_o.aluop      = (op_i == OP_BGTZ) ? ALUOP_IMM : ALUOP_SUB;
         end
         S_IEXE: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.aluop   = (op_i == OP_ADDI) ? ALUOP_ADD : ALUOP_IMM;
         end
         S_IWB: begin
            ctrl_o.regwrite   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.pcsrc      = PCSRC_JUMP;
            ctrl_o.pcwrite    = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// next-state logic, memory-wait watchdog and sticky flags.
// MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap and set illegal_op;
// otherwise they retire as a NOP and illegal_op is tied 0.
module multicycle_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       branch,
   output logic       bgtz,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop,
   output logic       instr_done,
   output logic       mem_timeout,
   output logic       illegal_op
);

   statetype_t state_q, state_d;
   ctrl_t      dec, ctrl;
   logic       timeout, illegal;

   mc_ctrl_outdec u_outdec (
      .state_i     (state_q),
      .op_i        (op),
      .mem_ready_i (mem_ready),
      .ctrl_o      (dec)
   );

   // Next-state selection; memory states hold until mem_ready
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW:                        state_d = S_MEMADR;
               OP_RTYPE, OP_SRLV:                   state_d = S_RTEXE;
               OP_BEQ, OP_BGTZ:                     state_d = S_BRANCH;
               OP_ADDI, OP_XORI, OP_LUI, OP_LI:     state_d = S_IEXE;
               OP_J:                                state_d = S_JUMP;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
               default:                             state_d = S_TRAP;
`else
               default:                             state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_RTEXE:  state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_IEXE:   state_d = S_IWB;
         S_IWB:    state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
         S_TRAP:   state_d = S_TRAP;
`endif
         default:  state_d = S_FETCH;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   generate
      if (MEM_WAIT_MAX > 0) begin : g_wdog
         localparam int unsigned   CW    = $clog2(MEM_WAIT_MAX + 1);
         localparam logic [CW-1:0] LIMIT = CW'(MEM_WAIT_MAX);
         logic          mem_wait;
         logic [CW-1:0] wait_q, wait_d;
         logic          timeout_q;

         // Waiting states never change state while mem_ready is low, so
         // clearing on "not waiting" also covers the state-change clear.
         assign mem_wait = !mem_ready &&
                           (state_q inside {S_FETCH, S_MEMRD, S_MEMWR});

         // Saturating count of consecutive memory wait cycles
         always_comb begin
            wait_d = '0;
            if (mem_wait) wait_d = (wait_q == LIMIT) ? LIMIT : wait_q + 1'b1;
         end

         // Wait counter and sticky timeout flag
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               wait_q    <= '0;
               timeout_q <= 1'b0;
            end else begin
               wait_q <= wait_d;
               if (wait_d == LIMIT) timeout_q <= 1'b1;
            end
         end

         assign timeout = timeout_q;
      end else begin : g_no_wdog
         assign timeout = 1'b0;
      end
   endgenerate

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
   logic illegal_q;

   // Sticky flag raised on entry to TRAP
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                 illegal_q <= 1'b0;
      else if (state_d == S_TRAP) illegal_q <= 1'b1;
   end

   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   // FETCH drives non-zero selects, so outputs are forced low while reset is held
   assign ctrl        = reset ? dec : '0;
   assign mem_timeout = reset & timeout;
   assign illegal_op  = reset & illegal;

   assign pcwrite    = ctrl.pcwrite;
   assign branch     = ctrl.branch;
   assign bgtz       = ctrl.bgtz;
   assign iord       = ctrl.iord;
   assign memwrite   = ctrl.memwrite;
   assign irwrite    = ctrl.irwrite;
   assign regdst     = ctrl.regdst;
   assign memtoreg   = ctrl.memtoreg;
   assign regwrite   = ctrl.regwrite;
   assign alusrca    = ctrl.alusrca;
   assign alusrcb    = ctrl.alusrcb;
   assign pcsrc      = ctrl.pcsrc;
   assign aluop      = ctrl.aluop;
   assign instr_done = ctrl.instr_done;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (MEM_WAIT_MAX = 4).
// Honours MULTICYCLE_CTRL_ILLEGAL_TRAP_EN for illegal-opcode expectations.
module tb_multicycle_ctrl;

   localparam int WAIT_MAX = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       mem_ready;
   logic       pcwrite, branch, bgtz, iord, memwrite, irwrite;
   logic       regdst, memtoreg, regwrite, alusrca, instr_done;
   logic       mem_timeout, illegal_op;
   logic [1:0] alusrcb, pcsrc, aluop;

   multicycle_ctrl #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
      .clk         (clk),
      .reset       (reset),
      .op          (op),
      .mem_ready   (mem_ready),
      .pcwrite     (pcwrite),
      .branch      (branch),
      .bgtz        (bgtz),
      .iord        (iord),
      .memwrite    (memwrite),
      .irwrite     (irwrite),
      .regdst      (regdst),
      .memtoreg    (memtoreg),
      .regwrite    (regwrite),
      .alusrca     (alusrca),
      .alusrcb     (alusrcb),
      .pcsrc       (pcsrc),
      .aluop       (aluop),
      .instr_done  (instr_done),
      .mem_timeout (mem_timeout),
      .illegal_op  (illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       bgtz;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
      logic       instr_done;
   } tb_out_t;

   // Phases of an instruction as seen by the reference model
   typedef enum int {K_F, K_D, K_MADR, K_MRD, K_MWB, K_MWR, K_REXE, K_AWB,
                     K_BR, K_IEXE, K_IWB, K_J, K_TRAP} kind_e;

   typedef struct {
      logic [5:0] op;
      int         lat;
      tb_out_t    c3;
   } vec_t;

   tb_out_t    act, last_out;
   int         checks = 0;
   int         errors = 0;

   // reference model state
   logic [5:0] cur_op;
   int         idx;
   int         run;
   logic       m_tout, m_ill;

   assign act = {pcwrite, branch, bgtz, iord, memwrite, irwrite, regdst,
                 memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop, instr_done};

   function automatic kind_e kind_at(input logic [5:0] o, input int i);
      kind_e k;
      if (i == 0)      k = K_F;
      else if (i == 1) k = K_D;
      else begin
         case (o)
            6'b100011: k = (i == 2) ? K_MADR : ((i == 3) ? K_MRD : K_MWB);
            6'b101011: k = (i == 2) ? K_MADR : K_MWR;
            6'b000000, 6'b000110: k = (i == 2) ? K_REXE : K_AWB;
            6'b000100, 6'b011101: k = K_BR;
            6'b001000, 6'b001110, 6'b001111, 6'b010001: k = (i == 2) ? K_IEXE : K_IWB;
            6'b000010: k = K_J;
            default:   k = K_TRAP;
         endcase
      end
      return k;
   endfunction

   // Number of phases with mem_ready tied high (= instruction latency)
   function automatic int plen(input logic [5:0] o);
      int n;
      case (o)
         6'b100011: n = 5;
         6'b101011, 6'b000000, 6'b000110,
         6'b001000, 6'b001110, 6'b001111, 6'b010001: n = 4;
         6'b000100, 6'b011101, 6'b000010: n = 3;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
         default: n = 3;
`else
         default: n = 2;
`endif
      endcase
      return n;
   endfunction

   function automatic tb_out_t exp_out(input kind_e k, input logic [5:0] o, input logic rdy);
      tb_out_t e;
      e = '0;
      case (k)
         K_F:    begin e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy; end
         K_D:    e.alusrcb = 2'b11;
         K_MADR: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
         K_MRD:  e.iord = 1'b1;
         K_MWB:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1; end
         K_MWR:  begin e.iord = 1'b1; e.memwrite = 1'b1; e.instr_done = rdy; end
         K_REXE: begin e.alusrca = 1'b1; e.aluop = 2'b10; end
         K_AWB:  begin e.regdst = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1; end
         K_BR: begin
            e.alusrca = 1'b1; e.pcsrc = 2'b01; e.branch = 1'b1; e.instr_done = 1'b1;
            e.bgtz  = (o == 6'b011101);
            e.aluop = (o == 6'b011101) ? 2'b11 : 2'b01;
         end
         K_IEXE: begin
            e.alusrca = 1'b1; e.alusrcb = 2'b10;
            e.aluop = (o == 6'b001000) ? 2'b00 : 2'b11;
         end
         K_IWB:  begin e.regwrite = 1'b1; e.instr_done = 1'b1; end
         K_J:    begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; e.instr_done = 1'b1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic tb_out_t co(input logic a, input logic [1:0] b, input logic [1:0] alu,
                                  input logic [1:0] pcs, input logic br, input logic bg,
                                  input logic pcw, input logic dn);
      tb_out_t e;
      e = '0;
      e.alusrca = a; e.alusrcb = b; e.aluop = alu; e.pcsrc = pcs;
      e.branch = br; e.bgtz = bg; e.pcwrite = pcw; e.instr_done = dn;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Advance the model across one rising edge
   task automatic advance(input kind_e k, input logic rdy);
      logic waiting;
      waiting = (k == K_F || k == K_MRD || k == K_MWR) && !rdy;
      if (waiting) begin
         if (run < WAIT_MAX) run++;
      end else begin
         run = 0;
      end
      if (run >= WAIT_MAX) m_tout = 1'b1;
      if (!(k == K_TRAP || waiting)) begin
         idx++;
         if (idx >= plen(cur_op)) idx = 0;
      end
      if (kind_at(cur_op, idx) == K_TRAP) m_ill = 1'b1;
   endtask

   // One clock: drive after negedge, compare, cross posedge, return at negedge
   task automatic step(input logic rdy);
      kind_e k;
      mem_ready = rdy;
      op = cur_op;
      #1;
      k = kind_at(cur_op, idx);
      chk($sformatf("ctrl[%s]", k.name()), 32'(act), 32'(exp_out(k, cur_op, rdy)));
      chk("mem_timeout", 32'(mem_timeout), 32'(m_tout));
      chk("illegal_op", 32'(illegal_op), 32'(m_ill));
      last_out = act;
      @(posedge clk);
      advance(k, rdy);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("reset_outs", 32'({act, mem_timeout, illegal_op}), 32'h0);
      idx = 0; run = 0; m_tout = 1'b0; m_ill = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_hold", 32'({act, mem_timeout, illegal_op}), 32'h0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Run until the model is back at the start of an instruction
   task automatic drain();
      for (int c = 0; c < 40 && idx != 0; c++) step(1'b1);
      if (idx != 0) chk("drain_bound", 32'(idx), 32'h0);
   endtask

   vec_t       tbl[11];
   logic [5:0] ops[14];

   initial begin
      #200000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1);
   end

   initial begin
      int   lat, ndone, nmw, done_last, mask;
      logic started;
      logic rw_seen;

      tbl[0]  = '{6'b100011, 5, co(1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0)};
      tbl[1]  = '{6'b101011, 4, co(1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0)};
      tbl[2]  = '{6'b000000, 4, co(1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0)};
      tbl[3]  = '{6'b000110, 4, co(1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0)};
      tbl[4]  = '{6'b000100, 3, co(1'b1, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1)};
      tbl[5]  = '{6'b011101, 3, co(1'b1, 2'b00, 2'b11, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1)};
      tbl[6]  = '{6'b001000, 4, co(1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0)};
      tbl[7]  = '{6'b001110, 4, co(1'b1, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0)};
      tbl[8]  = '{6'b001111, 4, co(1'b1, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0)};
      tbl[9]  = '{6'b010001, 4, co(1'b1, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0)};
      tbl[10] = '{6'b000010, 3, co(1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1)};
      for (int i = 0; i < 11; i++) ops[i] = tbl[i].op;
      ops[11] = 6'b000000;
      ops[12] = 6'b111111;
      ops[13] = 6'b101010;

      reset = 1'b0; op = '0; mem_ready = 1'b0; cur_op = '0;
      idx = 0; run = 0; m_tout = 1'b0; m_ill = 1'b0;
      @(negedge clk);
      do_reset();

      // Latency and third-cycle control vector per opcode
      foreach (tbl[i]) begin
         cur_op = tbl[i].op;
         lat = 0;
         for (int c = 1; c <= 20; c++) begin
            step(1'b1);
            if (c == 3) chk($sformatf("cycle3_op%b", tbl[i].op), 32'(last_out), 32'(tbl[i].c3));
            if (last_out.instr_done) begin lat = c; break; end
         end
         chk($sformatf("latency_op%b", tbl[i].op), 32'(lat), 32'(tbl[i].lat));
         drain();
      end

      // LW: writeback strobes only in cycle 5, one done pulse
      cur_op = 6'b100011; mask = 0; ndone = 0;
      for (int c = 0; c < 5; c++) begin
         step(1'b1);
         if (last_out.regwrite && last_out.memtoreg) mask |= (1 << c);
         if (last_out.instr_done) ndone++;
      end
      chk("lw_wb_cycle_mask", 32'(mask), 32'h10);
      chk("lw_done_count", 32'(ndone), 32'd1);

      // SW with three wait cycles in the write phase
      cur_op = 6'b101011; nmw = 0; ndone = 0; done_last = 0;
      for (int c = 0; c < 3; c++) step(1'b1);
      for (int w = 0; w < 4; w++) begin
         step(w == 3);
         if (last_out.memwrite) nmw++;
         if (last_out.instr_done) begin ndone++; done_last = (w == 3) ? 1 : 0; end
      end
      chk("sw_memwrite_cycles", 32'(nmw), 32'd4);
      chk("sw_done_count", 32'(ndone), 32'd1);
      chk("sw_done_on_4th", 32'(done_last), 32'd1);
      step(1'b1);
      chk("sw_back_to_fetch", 32'({last_out.alusrcb, last_out.irwrite}), 32'b011);
      drain();

      // Illegal opcode
      cur_op = 6'b111111; rw_seen = 1'b0;
      step(1'b1);
      step(1'b1);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      for (int c = 0; c < 3; c++) begin
         step(1'b1);
         chk("trap_no_strobes", 32'(last_out), 32'h0);
         chk("trap_illegal_sticky", 32'(illegal_op), 32'd1);
      end
      do_reset();
`else
      step(1'b1);
      chk("illegal_nop_fetch", 32'({last_out.alusrcb, last_out.irwrite}), 32'b011);
      rw_seen = last_out.regwrite | last_out.memwrite;
      chk("illegal_no_writes", 32'(rw_seen), 32'd0);
      chk("illegal_op_tied", 32'(illegal_op), 32'd0);
      drain();
`endif

      // Watchdog: four stalled fetch cycles
      cur_op = 6'b001000;
      for (int c = 0; c < 3; c++) step(1'b0);
      chk("wdog_below_limit", 32'(mem_timeout), 32'd0);
      step(1'b0);
      chk("wdog_at_limit", 32'(mem_timeout), 32'd1);
      for (int c = 0; c < 4; c++) step(1'b1);
      chk("wdog_sticky", 32'(mem_timeout), 32'd1);
      drain();
      do_reset();

      // Reset in the middle of a stalled store
      cur_op = 6'b101011;
      for (int c = 0; c < 3; c++) step(1'b1);
      mem_ready = 1'b0;
      #2;
      do_reset();
      step(1'b1);
      chk("post_reset_fetch", 32'({last_out.alusrcb, last_out.irwrite, last_out.memwrite}), 32'b0110);
      drain();

      // Randomised instruction stream against the model
      for (int n = 0; n < 80; n++) begin
         cur_op = ops[$urandom_range(0, 13)];
         started = 1'b0;
         for (int c = 0; c < 60; c++) begin
            step($urandom_range(0, 4) != 0);
            if (idx != 0) started = 1'b1;
            if (started && idx == 0) break;
            if (kind_at(cur_op, idx) == K_TRAP && c > 4) break;
         end
         if (idx != 0) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
